// File: rtl/operand_select_unit_if.sv
// operand_select_unit_if: decode-side bundle between ID and the operand select unit
// Carries the decode fields and flush into the unit and the mux selects/enables, stall and issue back out.
// master: decode stage side, slave: operand_select_unit side.
interface operand_select_unit_if #(
  parameter int A = 4
);
  logic         i_id_valid;
  logic [A-1:0] i_rs1;
  logic [A-1:0] i_rs2;
  logic [1:0]   i_src1;
  logic [1:0]   i_src2;
  logic [A-1:0] i_rd;
  logic         i_we;
  logic         i_load;
  logic         i_mul;
  logic         i_flush;
  logic [2:0]   o_sel_a;
  logic         o_en_a;
  logic [2:0]   o_sel_b;
  logic         o_en_b;
  logic         o_stall;
  logic         o_issue;
  modport master (
    output i_id_valid, i_rs1, i_rs2, i_src1, i_src2, i_rd, i_we, i_load, i_mul, i_flush,
    input  o_sel_a, o_en_a, o_sel_b, o_en_b, o_stall, o_issue
  );
  modport slave (
    input  i_id_valid, i_rs1, i_rs2, i_src1, i_src2, i_rd, i_we, i_load, i_mul, i_flush,
    output o_sel_a, o_en_a, o_sel_b, o_en_b, o_stall, o_issue
  );
endinterface

// File: rtl/operand_select_unit.sv
// operand_select_unit: forwarding selects and hazard stalls for the two ID/EX operand muxes
// Ports: clk; rst_n (async, active-low); bus (slave) carries decode fields and flush in,
// and sel/en for operands A and B, stall and issue out.
module operand_select_unit #(
  parameter int A       = 4,
  parameter int MUL_LAT = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_select_unit_if.slave bus
);
  logic         r_ex_v, r_ex_we, r_ex_load;
  logic         r_mem_v, r_mem_we, r_mem_load;
  logic         r_wb_v, r_wb_we;
  logic [A-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
  logic [3:0]   r_mul_cnt;
  logic [1:0][A-1:0] w_rs;
  logic [1:0][1:0]   w_src;
  logic [1:0][2:0]   w_sel;
  logic [1:0]   w_ex_hit, w_mem_hit, w_wb_hit, w_lu;
  logic         w_mul_busy, w_stall, w_issue;
  assign w_rs  = {bus.i_rs2, bus.i_rs1};
  assign w_src = {bus.i_src2, bus.i_src1};
  for (genvar i = 0; i < 2; i++) begin : g_op
    assign w_ex_hit[i]  = r_ex_v & r_ex_we & (r_ex_rd == w_rs[i]);
    assign w_mem_hit[i] = r_mem_v & r_mem_we & (r_mem_rd == w_rs[i]);
    assign w_wb_hit[i]  = r_wb_v & r_wb_we & (r_wb_rd == w_rs[i]);
    assign w_lu[i]      = ~|w_src[i] & |w_rs[i] & w_ex_hit[i] & r_ex_load;
    // Non-register sources map straight onto codes 101..111; youngest in-flight writer wins.
    assign w_sel[i] = !rst_n ? 3'b000 :
                      |w_src[i] ? {1'b1, w_src[i]} :
                      ~|w_rs[i] ? 3'b000 :
                      w_ex_hit[i] ? 3'b001 :
                      w_mem_hit[i] ? {2'b01, r_mem_load} :
                      w_wb_hit[i] ? 3'b100 : 3'b000;
  end
  assign w_mul_busy  = |r_mul_cnt;
  // A busy MUL stalls every decode slot, valid or not; flush overrides any stall.
  assign w_stall     = rst_n & ~bus.i_flush & (w_mul_busy | (bus.i_id_valid & |w_lu));
  assign w_issue     = rst_n & bus.i_id_valid & ~w_stall & ~bus.i_flush;
  assign bus.o_sel_a = w_sel[0];
  assign bus.o_sel_b = w_sel[1];
  assign bus.o_en_a  = w_issue;
  assign bus.o_en_b  = w_issue;
  assign bus.o_stall = w_stall;
  assign bus.o_issue = w_issue;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_v     <= 1'b0;
      r_ex_we    <= 1'b0;
      r_ex_load  <= 1'b0;
      r_ex_rd    <= '0;
      r_mem_v    <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_load <= 1'b0;
      r_mem_rd   <= '0;
      r_wb_v     <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_mul_cnt  <= '0;
    end else begin
      r_wb_v  <= r_mem_v;
      r_wb_we <= r_mem_we;
      r_wb_rd <= r_mem_rd;
      // While a MUL occupies EX, the MEM slot behind it receives bubbles.
      if (bus.i_flush || !w_mul_busy) begin
        r_mem_v    <= r_ex_v;
        r_mem_we   <= r_ex_we;
        r_mem_load <= r_ex_load;
        r_mem_rd   <= r_ex_rd;
      end else begin
        r_mem_v <= 1'b0;
      end
      if (bus.i_flush) begin
        r_ex_v    <= 1'b0;
        r_mul_cnt <= '0;
      end else if (w_mul_busy) begin
        r_mul_cnt <= r_mul_cnt - 4'd1;
      end else begin
        r_ex_v    <= w_issue;
        r_ex_we   <= bus.i_we;
        r_ex_load <= bus.i_load;
        r_ex_rd   <= bus.i_rd;
        r_mul_cnt <= (w_issue && bus.i_mul) ? 4'(MUL_LAT - 1) : 4'd0;
      end
    end
  end
endmodule

// File: doc/operand_select_unit.md
Name: operand_select_unit

Overview:
- Control stage directly upstream of the two 8:1 operand muxes (mux_8NtoN, N=32) at the ID/EX boundary.
- Tracks destination registers of in-flight instructions in EX, MEM and WB, including multi-cycle MUL and loads.
- Generates the 3-bit select and enable for operand A and operand B muxes.
- Raises stall_o on load-use and multi-cycle hazards.

Parameters:
- A, 4, register-address width (2^A architectural registers; register 0 hardwired zero)
- MUL_LAT, 3, EX occupancy of a MUL in cycles (legal 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  valid instruction in decode
- id_rs1_i  in  A  source register for operand A
- id_rs2_i  in  A  source register for operand B
- id_src1_i  in  2  operand A source type: 00 reg, 01 imm, 10 pc, 11 pc+4
- id_src2_i  in  2  operand B source type, same encoding
- id_rd_i  in  A  destination register
- id_we_i  in  1  instruction writes rd
- id_load_i  in  1  instruction is a load
- id_mul_i  in  1  instruction is a MUL
- flush_i  in  1  kill decode and EX contents (branch redirect)
- sel_a_o  out  3  operand A mux select
- en_a_o  out  1  operand A mux enable
- sel_b_o  out  3  operand B mux select
- en_b_o  out  1  operand B mux enable
- stall_o  out  1  hold fetch/decode this cycle
- issue_o  out  1  decode instruction enters EX at next edge

Behaviour:
- Mux input map:
  - 000 regfile
  - 001 EX result
  - 010 MEM ALU result
  - 011 MEM load data
  - 100 WB result
  - 101 immediate
  - 110 pc
  - 111 pc+4
- State registers:
  - EX: ex_v, ex_rd, ex_we, ex_load, ex_mul
  - MEM: mem_v, mem_rd, mem_we, mem_load
  - WB: wb_v, wb_rd, wb_we
  - mul_cnt[3:0]
- Reset (rst=0, async):
  - All state cleared.
  - Outputs forced to sel=000, en=0, stall_o=0, issue_o=0.
- Select per operand (combinational from registered state and decode inputs):
  - src=01/10/11 maps to 101/110/111.
  - src=00 with rs=0 maps to 000.
  - Otherwise the youngest match wins: EX match (v&we&rd==rs) gives 001; else MEM match gives 011 if mem_load, else 010; else WB match gives 100; else 000.
- Hazards (stall_o=1):
  - Load-use: ex_v & ex_load & ex_we & ex_rd==rs for any operand with src=00 and rs!=0.
  - MUL busy: mul_cnt != 0. This is a structural stall for every decode instruction, dependent or not.
  - stall_o is 0 whenever id_valid_i=0, except when MUL busy.
- en_x_o = id_valid_i & ~stall_o & ~flush_i. When en=0, sel still shows the computed value.
- issue_o = id_valid_i & ~stall_o & ~flush_i.
- Advance at each edge:
  - WB <= MEM, MEM <= EX.
  - EX <= decode if issue_o, else bubble (ex_v=0).
  - Exception while mul_cnt != 0: EX is held, MEM receives a bubble, WB <= MEM.
- MUL:
  - On issue of id_mul_i, mul_cnt <= MUL_LAT-1.
  - Decrements each cycle while nonzero.
  - On the cycle mul_cnt==0, the MUL is in its final EX cycle; dependents forward with 001.
  - MUL_LAT=1 behaves as a plain ALU op.
- flush_i:
  - EX <= bubble and mul_cnt <= 0 at the edge. MEM/WB advance normally.
  - Decode is not issued.
  - flush has priority over stall.
- Simultaneous: a load-use stall and a MUL busy condition in the same cycle give a single stall_o=1.
- Reset mid-MUL clears mul_cnt immediately, and stall_o drops asynchronously.

Test Plan:
1. Reset with rst=0 while id_valid_i=1, src1=00, rs1=5: en_a_o=0, sel_a_o=000, stall_o=0. Release rst; with no hazards: sel_a_o=000, en_a_o=1, issue_o=1.
2. Back-to-back dependency chain:
   - Issue ADD rd=3, then decode rs1=3: sel_a_o=001.
   - One cycle later (bubble between): sel_a_o=010.
   - Next: sel_a_o=100.
   - Then: sel_a_o=000.
3. Load-use:
   - Issue LOAD rd=7, next decode rs2=7: stall_o=1, en_b_o=0 for exactly 1 cycle.
   - Following cycle: sel_b_o=011, en_b_o=1, issue_o=1.
4. MUL with MUL_LAT=3:
   - Issue MUL rd=2, next decode rs1=4 (independent): stall_o=1 for 2 cycles.
   - Third cycle with rs1=2: sel_a_o=001, issue_o=1.
5. Source types:
   - src1=01, src2=11, rs=0 with EX writing r0: sel_a_o=101, sel_b_o=111.
   - src=00, rs=0: sel=000, never a forward code, no stall.
6. Flush and reset during MUL:
   - flush_i=1 one cycle after MUL issue: mul_cnt=0, stall_o=0 next cycle, issue_o=0 during flush.
   - Separately, rst=0 pulsed asynchronously mid-MUL: stall_o=0 immediately, all state cleared.
